// File: rtl/pe_operand_feeder_if.sv
// rtl/pe_operand_feeder_if.sv - command, operand-memory and PE-beat signals of pe_operand_feeder
interface pe_operand_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] cmd_a_base;
  logic [ADDR_WIDTH-1:0] cmd_b_base;
  logic [ADDR_WIDTH-1:0] cmd_b_stride;
  logic                  hold;
  logic                  a_rd_en;
  logic                  b_rd_en;
  logic [ADDR_WIDTH-1:0] a_rd_addr;
  logic [ADDR_WIDTH-1:0] b_rd_addr;
  logic [DATA_WIDTH-1:0] a_rd_data;
  logic [DATA_WIDTH-1:0] b_rd_data;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  valid_out;
  logic                  start;
  logic                  last;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_len, cmd_a_base, cmd_b_base, cmd_b_stride, hold,
    input  a_rd_data, b_rd_data,
    output cmd_ready, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
    output a, b, valid_out, start, last, done
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_a_base, cmd_b_base, cmd_b_stride, hold,
    output a_rd_data, b_rd_data,
    input  cmd_ready, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
    input  a, b, valid_out, start, last, done
  );
endinterface

// File: rtl/pe_operand_feeder.sv
// rtl/pe_operand_feeder.sv - streams K paired A/B operands to one MAC PE
// Define FEEDER_BSTRIDE_EN to walk B with cmd_b_stride instead of a fixed step of 1.
module pe_operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
) (
  input  logic clk,
  input  logic clr,
  pe_operand_feeder_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_nx;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  k;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [ADDR_WIDTH-1:0] b_step;
  logic                  handshake;
  logic                  zero_len;
  logic                  last_issue;
  logic                  issue;
  logic                  p1_valid, p1_start, p1_last;

`ifdef FEEDER_BSTRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_r;

  always_ff @(posedge clk) begin
    if (clr)
      stride_r <= '0;
    else if (handshake)
      stride_r <= bus.cmd_b_stride;
  end

  assign b_step = stride_r;
`else
  logic unused_stride;

  assign b_step        = ADDR_WIDTH'(1);
  assign unused_stride = ^bus.cmd_b_stride;
`endif

  assign handshake  = bus.cmd_valid && (state == IDLE) && !clr;
  assign zero_len   = (len_r == '0);
  assign last_issue = (k == len_r - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (clr)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (handshake) state_nx = ISSUE;
      ISSUE:   if (zero_len) state_nx = IDLE;
               else if (!bus.hold && last_issue) state_nx = DRAIN;
      DRAIN:   if (bus.valid_out && bus.last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    issue         = (state == ISSUE) && !zero_len && !bus.hold;
    bus.a_rd_en   = issue;
    bus.b_rd_en   = issue;
    bus.done      = ((state == ISSUE) && zero_len) ||
                    ((state == DRAIN) && bus.valid_out && bus.last);
  end

  assign bus.a_rd_addr = a_addr;
  assign bus.b_rd_addr = b_addr;

  // Two-stage framing pipe: p1 tracks the memory read, the output stage holds the beat.
  always_ff @(posedge clk) begin
    if (clr) begin
      len_r         <= '0;
      k             <= '0;
      a_addr        <= '0;
      b_addr        <= '0;
      p1_valid      <= 1'b0;
      p1_start      <= 1'b0;
      p1_last       <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.start     <= 1'b0;
      bus.last      <= 1'b0;
      bus.a         <= '0;
      bus.b         <= '0;
    end else begin
      if (handshake) begin
        len_r  <= bus.cmd_len;
        k      <= '0;
        a_addr <= bus.cmd_a_base;
        b_addr <= bus.cmd_b_base;
      end else if (issue) begin
        k      <= k + LEN_WIDTH'(1);
        a_addr <= a_addr + ADDR_WIDTH'(1);
        b_addr <= b_addr + b_step;
      end
      p1_valid      <= issue;
      p1_start      <= issue && (k == '0);
      p1_last       <= issue && last_issue;
      bus.valid_out <= p1_valid;
      bus.start     <= p1_start;
      bus.last      <= p1_last;
      if (p1_valid) begin
        bus.a <= bus.a_rd_data;
        bus.b <= bus.b_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb/tb_pe_operand_feeder.sv - directed scoreboard bench for pe_operand_feeder
module tb_pe_operand_feeder;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 10;
`ifdef FEEDER_BSTRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          s;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  beat_t         sb[$];
  logic [AW-1:0] exp_a_addr[$];
  logic [AW-1:0] exp_b_addr[$];

  always #5 clk = ~clk;

  pe_operand_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  pe_operand_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  function automatic logic [DW-1:0] a_word(input logic [AW-1:0] ad);
    return {12'hA00, 10'h000, ad};
  endfunction

  function automatic logic [DW-1:0] b_word(input logic [AW-1:0] ad);
    return {12'hB00, 10'h155, ad};
  endfunction

  always @(posedge clk) begin
    if (bus.a_rd_en) bus.a_rd_data <= a_word(bus.a_rd_addr);
    if (bus.b_rd_en) bus.b_rd_data <= b_word(bus.b_rd_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int len, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input logic [AW-1:0] st, input logic [31:0] hold_m,
                         input logic [31:0] strobe_m, input logic [31:0] beat_m,
                         input int done_c);
    int    step_v;
    beat_t bt;
    step_v = STRIDE_EN ? int'(st) : 1;
    for (int k = 0; k < len; k++) begin
      exp_a_addr.push_back(ab + AW'(k));
      exp_b_addr.push_back(bb + AW'(k * step_v));
      sb.push_back('{a_word(ab + AW'(k)), b_word(bb + AW'(k * step_v)), k == 0, k == len - 1});
    end
    step();
    bus.cmd_valid    = 1'b1;
    bus.cmd_len      = LW'(len);
    bus.cmd_a_base   = ab;
    bus.cmd_b_base   = bb;
    bus.cmd_b_stride = st;
    #1;
    check("cmd_ready_c0", bus.cmd_ready, 1);
    for (int c = 1; c <= done_c + 2; c++) begin
      step();
      bus.cmd_valid = 1'b0;
      bus.hold      = hold_m[c];
      #1;
      check($sformatf("rd_en_c%0d", c), bus.a_rd_en, strobe_m[c]);
      check($sformatf("rd_en_eq_c%0d", c), bus.b_rd_en, bus.a_rd_en);
      if (bus.a_rd_en) begin
        if (exp_a_addr.size() == 0) begin
          check($sformatf("extra_strobe_c%0d", c), 1, 0);
        end else begin
          check($sformatf("a_addr_c%0d", c), bus.a_rd_addr, exp_a_addr.pop_front());
          check($sformatf("b_addr_c%0d", c), bus.b_rd_addr, exp_b_addr.pop_front());
        end
      end
      check($sformatf("valid_c%0d", c), bus.valid_out, beat_m[c]);
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          check($sformatf("extra_beat_c%0d", c), 1, 0);
        end else begin
          bt = sb.pop_front();
          check($sformatf("a_c%0d", c), bus.a, bt.a);
          check($sformatf("b_c%0d", c), bus.b, bt.b);
          check($sformatf("start_c%0d", c), bus.start, bt.s);
          check($sformatf("last_c%0d", c), bus.last, bt.l);
        end
      end else begin
        check($sformatf("framing_idle_c%0d", c), {bus.start, bus.last}, 0);
      end
      check($sformatf("done_c%0d", c), bus.done, c == done_c);
      check($sformatf("cmd_ready_c%0d", c), bus.cmd_ready, c > done_c);
    end
    bus.hold = 1'b0;
    check("sb_empty", sb.size(), 0);
    check("addr_q_empty", exp_a_addr.size(), 0);
    sb.delete();
    exp_a_addr.delete();
    exp_b_addr.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr              = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_len      = '0;
    bus.cmd_a_base   = '0;
    bus.cmd_b_base   = '0;
    bus.cmd_b_stride = '0;
    bus.hold         = 1'b0;
    repeat (3) step();
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(4);
    step();
    clr           = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rd_en", {bus.a_rd_en, bus.b_rd_en}, 0);
    check("rst_addr", {bus.a_rd_addr, bus.b_rd_addr}, 0);
    check("rst_ab", {bus.a, bus.b}, 0);
    check("rst_frame", {bus.valid_out, bus.start, bus.last, bus.done}, 0);

    run_cmd(4, 10'h010, 10'h020, 10'h001, 32'h0, 32'h1E, 32'h78, 6);
    run_cmd(1, 10'h050, 10'h060, 10'h001, 32'h0, 32'h02, 32'h08, 3);
    run_cmd(0, 10'h070, 10'h080, 10'h001, 32'h0, 32'h00, 32'h00, 1);
    run_cmd(3, 10'h0A0, 10'h0B0, 10'h001, 32'h0C, 32'h32, 32'hC8, 7);
    run_cmd(3, 10'h3FE, 10'h3FE, 10'h008, 32'h0, 32'h0E, 32'h38, 5);

    step();
    bus.cmd_valid  = 1'b1;
    bus.cmd_len    = LW'(8);
    bus.cmd_a_base = 10'h100;
    bus.cmd_b_base = 10'h200;
    for (int c = 1; c <= 4; c++) begin
      step();
      bus.cmd_valid = 1'b0;
      #1;
      if (c == 3) check("midrst_beat_c3", bus.valid_out, 1);
    end
    step();
    clr = 1'b1;
    for (int c = 6; c <= 14; c++) begin
      step();
      clr = 1'b0;
      #1;
      check($sformatf("midrst_ready_c%0d", c), bus.cmd_ready, 1);
      check($sformatf("midrst_frame_c%0d", c), {bus.valid_out, bus.start, bus.last, bus.done}, 0);
      check($sformatf("midrst_rd_c%0d", c), {bus.a_rd_en, bus.b_rd_en, bus.a_rd_addr, bus.b_rd_addr}, 0);
      check($sformatf("midrst_ab_c%0d", c), {bus.a, bus.b}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
